// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int DATA_BITS = 8;

  function automatic int baud_div(input int src, input int baud);
    return src / baud;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake: byte-pending flags and data in, accept pulses and grant index out.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0][7:0] data_in;
  logic [NUM_REQ-1:0]      ack;
  logic [IDW-1:0]          grant_id;

  modport master (output req, data_in, input ack, grant_id);
  modport slave  (input req, data_in, output ack, grant_id);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period divider: tick marks the last hwclk cycle of each DIV-cycle bit slot.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CNTR_W = 32,
  parameter int DIV    = 4
) (
  input  logic hwclk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [CNTR_W-1:0] LAST = CNTR_W'(DIV - 1);

  logic [CNTR_W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Held at zero while clr is high so the first slot after release is full width.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter; baud timing is a clock enable on hwclk.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SOURCE_CLK = 12000000,
  parameter int BAUD       = 9600,
  parameter int CNTR_W     = 32
) (
  input  logic              hwclk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus,
  output logic              ftdi_tx,
  output logic              tx_active,
  output logic              frame_sent
);

  localparam int DIV = baud_div(SOURCE_CLK, BAUD);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [BW-1:0]  LAST_IDX = BW'(DATA_BITS - 1);
  localparam logic [IDW-1:0] RR_INIT  = IDW'(NUM_REQ - 1);

  if (DIV < 2) begin : g_div_err
    $error("uart_tx_arbiter: SOURCE_CLK/BAUD must be at least 2");
  end

  state_t                  state, state_nx;
  logic                    tick;
  logic [7:0]              shift, shift_nx;
  logic [BW-1:0]           bit_idx, bit_idx_nx;
  logic [IDW-1:0]          rr_last, rr_nx, grant_nx;
  logic [IDW-1:0]          sel, cand;
  logic                    found;
  logic [NUM_REQ-1:0]      ack_nx;
  logic                    tx_nx, act_nx;

  uart_baud_tick #(
    .CNTR_W (CNTR_W),
    .DIV    (DIV)
  ) u_tick (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .tick  (tick)
  );

  // Scan from the index after the last winner, wrapping, and take the first pending request.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(rr_last) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift        <= '0;
      bit_idx      <= '0;
      rr_last      <= RR_INIT;
      bus.grant_id <= '0;
      bus.ack      <= '0;
      ftdi_tx      <= 1'b1;
      tx_active    <= 1'b0;
    end else begin
      state        <= state_nx;
      shift        <= shift_nx;
      bit_idx      <= bit_idx_nx;
      rr_last      <= rr_nx;
      bus.grant_id <= grant_nx;
      bus.ack      <= ack_nx;
      ftdi_tx      <= tx_nx;
      tx_active    <= act_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = START;
      START:   if (tick) state_nx = DATA;
      DATA:    if (tick && bit_idx == LAST_IDX) state_nx = STOP;
      STOP:    if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; ftdi_tx is computed one cycle early so the pin is a flop.
  always_comb begin
    tx_nx      = ftdi_tx;
    ack_nx     = '0;
    shift_nx   = shift;
    bit_idx_nx = bit_idx;
    grant_nx   = bus.grant_id;
    rr_nx      = rr_last;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (found) begin
          tx_nx       = 1'b0;
          ack_nx[sel] = 1'b1;
          shift_nx    = bus.data_in[sel];
          grant_nx    = sel;
          rr_nx       = sel;
        end
      end
      START: begin
        if (tick) begin
          tx_nx      = shift[0];
          bit_idx_nx = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_nx   = shift >> 1;
          bit_idx_nx = bit_idx + 1'b1;
          tx_nx      = (bit_idx == LAST_IDX) ? 1'b1 : shift[1];
        end
      end
      STOP: begin
        if (tick) tx_nx = 1'b1;
      end
      default: tx_nx = 1'b1;
    endcase
  end

  assign act_nx     = (state_nx != IDLE);
  assign frame_sent = (state == STOP) && tick;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed checks of the UART arbiter against a frame-level model of the line.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int F   = 10 * DIV;

  logic clk = 1'b0;
  logic rst_n;
  logic tx, act, fs;
  logic tx2, act2, fs2;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   m_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus2 ();

  uart_tx_arbiter #(.NUM_REQ(N), .SOURCE_CLK(40), .BAUD(10), .CNTR_W(32)) u_dut (
    .hwclk(clk), .rst_n(rst_n), .bus(bus.slave),
    .ftdi_tx(tx), .tx_active(act), .frame_sent(fs)
  );

  uart_tx_arbiter #(.NUM_REQ(N)) u_dflt (
    .hwclk(clk), .rst_n(rst_n), .bus(bus2.slave),
    .ftdi_tx(tx2), .tx_active(act2), .frame_sent(fs2)
  );

  // Round-robin rule: first pending index after the previous winner, wrapping.
  function automatic int model_pick(input int last, input logic [N-1:0] pend);
    for (int k = 1; k <= N; k++)
      if (pend[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin r = i; c++; end
    return (c == 1) ? r : -1;
  endfunction

  task automatic wait_ack(input int max, output int n);
    n = -1;
    for (int i = 0; i <= max; i++) begin
      if (bus.ack !== '0) begin n = i; break; end
      @(negedge clk);
    end
  endtask

  // Samples one frame starting at the ack cycle; optionally pulses poke_m on req at cycle poke_t.
  task automatic receive_frame(input int poke_t, input logic [N-1:0] poke_m,
                               output logic [7:0] data, output int bad);
    logic [F-1:0] line;
    bad = 0;
    for (int t = 0; t < F; t++) begin
      if (t > 0) @(negedge clk);
      if (t == poke_t)     bus.req = bus.req | poke_m;
      if (t == poke_t + 1) bus.req = bus.req & ~poke_m;
      line[t] = tx;
      if (fs !== (t == F - 1)) bad++;
      if (act !== 1'b1) bad++;
      if (t > 0 && bus.ack !== '0) bad++;
    end
    for (int s = 0; s < 10; s++)
      for (int c = 1; c < DIV; c++)
        if (line[s*DIV + c] !== line[s*DIV]) bad++;
    if (line[0] !== 1'b0) bad++;
    if (line[9*DIV] !== 1'b1) bad++;
    for (int b = 0; b < 8; b++) data[b] = line[(b + 1) * DIV];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    m_last = N - 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0;  bus.data_in = '0;
    bus2.req = '0; bus2.data_in = '0;
    repeat (3) @(negedge clk);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
    tests++; if (act !== 1'b0) begin fails++; $display("FAIL reset_active: got %b expected 0", act); end
    tests++; if (fs !== 1'b0) begin fails++; $display("FAIL reset_frame_sent: got %b expected 0", fs); end
    tests++; if (bus.ack !== '0) begin fails++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
    tests++; if (bus.grant_id !== '0) begin fails++; $display("FAIL reset_grant: got %0d expected 0", bus.grant_id); end
    rst_n  = 1'b1;
    m_last = N - 1;
    repeat (3) @(negedge clk);
    tests++; if (tx !== 1'b1 || act !== 1'b0) begin fails++; $display("FAIL idle_line: got tx=%b act=%b expected tx=1 act=0", tx, act); end
  endtask

  task automatic test_single();
    int n, id, exp, bad;
    logic [7:0] d;
    bus.data_in[0] = 8'h48;
    bus.req = 4'b0001;
    wait_ack(20, n);
    exp = model_pick(m_last, 4'b0001);
    tests++; if (n != 1) begin fails++; $display("FAIL single_latency: got %0d expected 1", n); end
    id = onehot_idx(bus.ack);
    tests++; if (id != exp) begin fails++; $display("FAIL single_ack: got %b expected index %0d", bus.ack, exp); end
    tests++; if (bus.grant_id !== 2'(exp)) begin fails++; $display("FAIL single_grant: got %0d expected %0d", bus.grant_id, exp); end
    bus.req[0] = 1'b0;
    receive_frame(-5, '0, d, bad);
    tests++; if (d !== 8'h48) begin fails++; $display("FAIL single_data: got %h expected 48", d); end
    tests++; if (bad != 0) begin fails++; $display("FAIL single_framing: got %0d bad samples expected 0", bad); end
    m_last = exp;
    @(negedge clk);
    tests++; if (act !== 1'b0 || tx !== 1'b1) begin fails++; $display("FAIL single_gap: got act=%b tx=%b expected 0/1", act, tx); end
  endtask

  task automatic test_round_robin();
    int n, id, exp, bad, prev;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < N; i++) bus.data_in[i] = 8'hA0 + 8'(i);
    bus.req = '1;
    prev = 0;
    for (int k = 0; k < N + 1; k++) begin
      wait_ack(F + 5, n);
      tests++;
      if (n < 0) begin fails++; $display("FAIL rr_timeout: got no ack expected ack %0d", k); break; end
      id  = onehot_idx(bus.ack);
      exp = model_pick(m_last, '1);
      if (id != exp || id != k % N) begin fails++; $display("FAIL rr_order: got %0d expected %0d", id, exp); end
      if (k > 0) begin
        tests++; if (cyc - prev != F + 1) begin fails++; $display("FAIL rr_spacing: got %0d expected %0d", cyc - prev, F + 1); end
      end
      prev = cyc;
      receive_frame(-5, '0, d, bad);
      tests++; if (d !== 8'hA0 + 8'(exp) || bad != 0) begin fails++; $display("FAIL rr_data: got %h bad=%0d expected %h", d, bad, 8'hA0 + 8'(exp)); end
      m_last = exp;
    end
    bus.req = '0;
  endtask

  task automatic test_withdrawal();
    int n, id, bad, cnt;
    logic [7:0] d;
    bus.data_in[1] = 8'h3C;
    bus.data_in[2] = 8'hFF;
    bus.req = 4'b0010;
    wait_ack(20, n);
    id = onehot_idx(bus.ack);
    tests++; if (id != model_pick(m_last, 4'b0010)) begin fails++; $display("FAIL wd_ack: got %b expected index 1", bus.ack); end
    bus.req[1] = 1'b0;
    receive_frame(15, 4'b0100, d, bad);
    tests++; if (d !== 8'h3C || bad != 0) begin fails++; $display("FAIL wd_frame: got %h bad=%0d expected 3c", d, bad); end
    m_last = 1;
    cnt = 0;
    for (int t = 0; t < 3 * DIV; t++) begin
      @(negedge clk);
      if (act !== 1'b0 || tx !== 1'b1 || bus.ack !== '0) cnt++;
    end
    tests++; if (cnt != 0) begin fails++; $display("FAIL wd_idle: got %0d busy cycles expected 0", cnt); end
  endtask

  task automatic test_priority();
    int n, id, exp, bad;
    logic [7:0] d;
    bus.data_in[3] = 8'h33;
    bus.req = 4'b1000;
    wait_ack(20, n);
    id = onehot_idx(bus.ack);
    tests++; if (id != 3) begin fails++; $display("FAIL prio_first: got %b expected index 3", bus.ack); end
    bus.req = '0;
    receive_frame(-5, '0, d, bad);
    m_last = 3;
    bus.data_in[0] = 8'h11;
    bus.req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      wait_ack(20, n);
      exp = model_pick(m_last, bus.req);
      id  = onehot_idx(bus.ack);
      tests++; if (id != exp || n < 0) begin fails++; $display("FAIL prio_order: got %0d expected %0d", id, exp); end
      if (exp >= 0) bus.req[exp] = 1'b0;
      receive_frame(-5, '0, d, bad);
      tests++; if (d !== (exp == 0 ? 8'h11 : 8'h33) || bad != 0) begin fails++; $display("FAIL prio_data: got %h bad=%0d", d, bad); end
      m_last = exp;
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, id, exp, bad, fs_seen;
    logic [7:0] d;
    logic [7:0] b0;
    bus.data_in[2] = 8'h96;
    bus.req = 4'b0100;
    wait_ack(20, n);
    tests++; if (onehot_idx(bus.ack) != model_pick(m_last, 4'b0100)) begin fails++; $display("FAIL rmf_ack: got %b expected index 2", bus.ack); end
    bus.req = '0;
    repeat (17) @(negedge clk);
    tests++; if (tx !== 1'b0) begin fails++; $display("FAIL rmf_bit3: got %b expected 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rmf_async_tx: got %b expected 1", tx); end
    tests++; if (act !== 1'b0 || fs !== 1'b0 || bus.ack !== '0 || bus.grant_id !== '0)
      begin fails++; $display("FAIL rmf_outputs: got act=%b fs=%b ack=%b grant=%0d expected all 0", act, fs, bus.ack, bus.grant_id); end
    fs_seen = 0;
    repeat (3) begin @(negedge clk); if (fs !== 1'b0 || tx !== 1'b1) fs_seen++; end
    tests++; if (fs_seen != 0) begin fails++; $display("FAIL rmf_hold: got %0d bad cycles expected 0", fs_seen); end
    rst_n  = 1'b1;
    m_last = N - 1;
    @(negedge clk);
    b0 = 8'($urandom);
    bus.data_in[0] = b0;
    bus.data_in[1] = 8'h55;
    bus.req = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      wait_ack(20, n);
      exp = model_pick(m_last, bus.req);
      id  = onehot_idx(bus.ack);
      tests++; if (id != exp || n < 0) begin fails++; $display("FAIL rmf_order: got %0d expected %0d", id, exp); end
      if (exp >= 0) bus.req[exp] = 1'b0;
      receive_frame(-5, '0, d, bad);
      tests++; if (d !== (exp == 0 ? b0 : 8'h55) || bad != 0) begin fails++; $display("FAIL rmf_data: got %h bad=%0d", d, bad); end
      m_last = exp;
    end
  endtask

  task automatic test_random();
    int n, id, exp, bad;
    logic [N-1:0] pend;
    logic [7:0] bytes [N];
    logic [7:0] d;
    pend = '0;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          bytes[i] = 8'($urandom);
          bus.data_in[i] = bytes[i];
        end
      if (pend == '0) begin
        id = $urandom_range(0, N - 1);
        pend[id] = 1'b1;
        bytes[id] = 8'($urandom);
        bus.data_in[id] = bytes[id];
      end
      bus.req = pend;
      wait_ack(10, n);
      exp = model_pick(m_last, pend);
      id  = onehot_idx(bus.ack);
      tests++;
      if (n < 0 || id != exp) begin fails++; $display("FAIL rand_grant: got %0d expected %0d", id, exp); break; end
      pend[exp] = 1'b0;
      bus.req = pend;
      receive_frame(-5, '0, d, bad);
      tests++; if (d !== bytes[exp] || bad != 0) begin fails++; $display("FAIL rand_data: got %h bad=%0d expected %h", d, bad, bytes[exp]); end
      m_last = exp;
    end
    bus.req = '0;
  endtask

  task automatic test_default_timing();
    int n, len;
    logic [9:0] smp;
    logic [7:0] d;
    bus2.data_in[0] = 8'hA5;
    bus2.req = 4'b0001;
    n = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus2.ack !== '0) begin n = i; break; end
    end
    tests++;
    if (n < 0) begin fails++; $display("FAIL dflt_ack: got no ack expected ack"); return; end
    bus2.req = '0;
    len = -1;
    smp = '0;
    for (int t = 0; t < 13000; t++) begin
      if (t > 0) @(negedge clk);
      if (t % 1250 == 625) smp[t / 1250] = tx2;
      if (fs2 === 1'b1) begin len = t + 1; break; end
    end
    tests++; if (len != 12500) begin fails++; $display("FAIL dflt_len: got %0d expected 12500", len); end
    d = smp[8:1];
    tests++; if (d !== 8'hA5 || smp[0] !== 1'b0 || smp[9] !== 1'b1)
      begin fails++; $display("FAIL dflt_frame: got %b expected 1_10100101_0", smp); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_withdrawal();
    test_priority();
    test_reset_mid_frame();
    test_random();
    test_default_timing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
